// File: rtl/serv_dbg_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : serv_dbg_pkg
//  Description : Shared definitions for the SERV debug Wishbone responder:
//                halt/resume state encodings, register offsets within the
//                debug window, the ebreak opcode and a byte-merge helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package serv_dbg_pkg;

    // Handshake states; the encoding is visible to firmware through STATUS
    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_HALTREQ   = 2'd1,
        ST_HALTED    = 2'd2,
        ST_RESUMEREQ = 2'd3
    } dbg_state_t;

    // Word offsets within the debug window (byte address bits [4:2])
    localparam logic [2:0] c_off_status  = 3'd0;
    localparam logic [2:0] c_off_halted  = 3'd1;
    localparam logic [2:0] c_off_resumed = 3'd2;
    localparam logic [2:0] c_off_data0   = 3'd3;

    // Program buffer words power up holding ebreak so a stray jump into an
    // unloaded buffer drops straight back into the debug handler
    localparam logic [31:0] c_ebreak = 32'h0010_0073;

    // Replace only the byte lanes selected by sel, keep the rest of cur
    function automatic logic [31:0] merge_bytes(
        input logic [31:0] cur,
        input logic [31:0] wdat,
        input logic [3:0]  sel
    );
        logic [31:0] res;
        res = cur;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) begin
                res[8*b +: 8] = wdat[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serv_dbg_wb_responder.sv
`default_nettype none
// ============================================================================
//  Module      : serv_dbg_wb_responder
//  Description : Wishbone responder for the SERV debug window. Runs the
//                halt/resume handshake between an external debug host and
//                the core, drives the core debug interrupt and exposes a
//                32-bit mailbox (DATA0) to both sides.
//                Optional macro SERV_DBG_PROGBUF_EN adds a 4-word program
//                buffer at offsets 4-7 with its own host write port.
//  Revision    : 1.0 - initial release
// ============================================================================
module serv_dbg_wb_responder
    import serv_dbg_pkg::*;
#(
    parameter logic [31:0] MBOX_RST = 32'h0
) (
    input  logic        clk,
    input  logic        i_rst,
    // Core data bus (Wishbone, cyc doubles as strobe)
    input  logic [31:0] i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic [3:0]  i_wb_sel,
    input  logic        i_wb_we,
    input  logic        i_wb_cyc,
    output logic [31:0] o_wb_rdt,
    output logic        o_wb_ack,
    // Core debug interrupt
    output logic        o_debug_interrupt,
    // Debug host side
    input  logic        i_host_haltreq,
    input  logic        i_host_resumereq,
    output logic        o_host_halted,
    input  logic        i_host_data_we,
    input  logic [31:0] i_host_data,
`ifdef SERV_DBG_PROGBUF_EN
    input  logic        i_host_pb_we,
    input  logic [1:0]  i_host_pb_adr,
    input  logic [31:0] i_host_pb_dat,
`endif
    output logic [31:0] o_host_data
);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    dbg_state_t  r_state;
    logic        r_debug_interrupt;
    logic        r_host_halted;
    logic        r_wb_ack;
    logic [31:0] r_wb_rdt;
    logic [31:0] r_data0;
`ifdef SERV_DBG_PROGBUF_EN
    logic [31:0] r_progbuf [4];
`endif

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic [2:0]  w_offset;
    logic        w_ack_edge;
    logic        w_core_wr;
    logic        w_wr_halted;
    logic        w_wr_resumed;
    logic        w_wr_data0;
    logic [31:0] w_rd_data;
    dbg_state_t  w_state_nxt;
    logic        w_unused_adr;

    assign w_offset     = i_wb_adr[4:2];
    // The acking edge is the only edge on which a bus access takes effect
    assign w_ack_edge   = i_wb_cyc & ~r_wb_ack;
    assign w_core_wr    = w_ack_edge & i_wb_we;
    assign w_wr_halted  = w_core_wr & (w_offset == c_off_halted);
    assign w_wr_resumed = w_core_wr & (w_offset == c_off_resumed);
    assign w_wr_data0   = w_core_wr & (w_offset == c_off_data0);

    // The SoC decoder has already qualified cyc with the upper address bits
    assign w_unused_adr = ^{i_wb_adr[31:5], i_wb_adr[1:0]};

    // ------------------------------------------------------------------
    // Handshake next state. Core writes take priority: when a core write
    // moves the state, a host pulse on the same edge is discarded.
    // ------------------------------------------------------------------
    // Next-state selection for the halt/resume handshake
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_wr_halted) begin
                    // ebreak entry without a host request
                    w_state_nxt = ST_HALTED;
                end else if (i_host_haltreq) begin
                    w_state_nxt = ST_HALTREQ;
                end
            end
            ST_HALTREQ: begin
                if (w_wr_halted) begin
                    w_state_nxt = ST_HALTED;
                end
            end
            ST_HALTED: begin
                if (i_host_resumereq) begin
                    w_state_nxt = ST_RESUMEREQ;
                end
            end
            ST_RESUMEREQ: begin
                if (w_wr_resumed) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // State register; interrupt and halted flags follow the next state so
    // they switch on the same edge as the state itself
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_state           <= ST_RUN;
            r_debug_interrupt <= 1'b0;
            r_host_halted     <= 1'b0;
        end else begin
            r_state           <= w_state_nxt;
            r_debug_interrupt <= (w_state_nxt == ST_HALTREQ);
            r_host_halted     <= (w_state_nxt == ST_HALTED);
        end
    end

    // ------------------------------------------------------------------
    // Read data multiplexer (pre-edge register values)
    // ------------------------------------------------------------------
    // Select read data for the addressed register
    always_comb begin
        w_rd_data = 32'h0;
        case (w_offset)
            c_off_status: begin
                w_rd_data = {28'h0, r_state,
                             (r_state == ST_RESUMEREQ),
                             (r_state == ST_HALTREQ)};
            end
            c_off_data0: begin
                w_rd_data = r_data0;
            end
`ifdef SERV_DBG_PROGBUF_EN
            3'd4, 3'd5, 3'd6, 3'd7: begin
                w_rd_data = r_progbuf[w_offset[1:0]];
            end
`endif
            default: begin
                // HALTED/RESUMED are write-only; unmapped offsets read zero
                w_rd_data = 32'h0;
            end
        endcase
    end

    // Single-cycle ack; read data is only non-zero while ack is high
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_wb_ack <= 1'b0;
            r_wb_rdt <= 32'h0;
        end else begin
            r_wb_ack <= w_ack_edge;
            if (w_ack_edge && !i_wb_we) begin
                r_wb_rdt <= w_rd_data;
            end else begin
                r_wb_rdt <= 32'h0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Mailbox
    // ------------------------------------------------------------------
    // DATA0 update: the host owns the whole word on a collision
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_data0 <= MBOX_RST;
        end else if (i_host_data_we) begin
            r_data0 <= i_host_data;
        end else if (w_wr_data0) begin
            r_data0 <= merge_bytes(r_data0, i_wb_dat, i_wb_sel);
        end
    end

`ifdef SERV_DBG_PROGBUF_EN
    // Program buffer update: host write wins over a core write to the same word
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < 4; i++) begin
                r_progbuf[i] <= c_ebreak;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (i_host_pb_we && (i_host_pb_adr == i[1:0])) begin
                    r_progbuf[i] <= i_host_pb_dat;
                end else if (w_core_wr && w_offset[2] && (w_offset[1:0] == i[1:0])) begin
                    r_progbuf[i] <= merge_bytes(r_progbuf[i], i_wb_dat, i_wb_sel);
                end
            end
        end
    end
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_wb_ack          = r_wb_ack;
    assign o_wb_rdt          = r_wb_rdt;
    assign o_debug_interrupt = r_debug_interrupt;
    assign o_host_halted     = r_host_halted;
    assign o_host_data       = r_data0;

endmodule
`default_nettype wire
